// File: rtl/wb_arb_pkg.sv
// ============================================================================
// wb_arb_pkg : shared constants and state encoding for the Wishbone port arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package wb_arb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/wb_arb_rr_pick.sv
// ============================================================================
// wb_arb_rr_pick : round-robin picker, first requester after i_last (wrapping)
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_arb_rr_pick #(
  parameter int NR_PORTS = 3,
  parameter int IW       = 2
) (
  input  logic [NR_PORTS-1:0] i_req,
  input  logic [IW-1:0]       i_last,
  output logic [NR_PORTS-1:0] o_grant,
  output logic [IW-1:0]       o_idx,
  output logic                o_valid
);

  logic [IW-1:0] w_cand;

  // Walk offsets from farthest to nearest so the nearest requester after i_last wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int i = NR_PORTS; i >= 1; i--) begin
      w_cand = IW'((int'(i_last) + i) % NR_PORTS);
      if (i_req[w_cand]) begin
        o_grant = {{(NR_PORTS-1){1'b0}}, 1'b1} << w_cand;
        o_idx   = w_cand;
        o_valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_sdram_port_arbiter.sv
// ============================================================================
// wb_sdram_port_arbiter : round-robin sharing of the SDRAM controller Wishbone
// port between NR_PORTS slave ports, ownership locked for a whole cycle/burst.
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_sdram_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NR_PORTS = 3,
  parameter int AW       = 30,
  parameter int DW       = 32,
  parameter int TIMEOUT  = 255
) (
  input  logic                     wb_clk,
  input  logic                     wb_rst,
  input  logic [NR_PORTS-1:0]      wbs_cyc_i,
  input  logic [NR_PORTS-1:0]      wbs_stb_i,
  input  logic [NR_PORTS-1:0]      wbs_we_i,
  input  logic [NR_PORTS*AW-1:0]   wbs_adr_i,
  input  logic [NR_PORTS*DW-1:0]   wbs_dat_i,
  input  logic [NR_PORTS*DW/8-1:0] wbs_sel_i,
  input  logic [NR_PORTS*3-1:0]    wbs_cti_i,
  input  logic [NR_PORTS*2-1:0]    wbs_bte_i,
  output logic [NR_PORTS-1:0]      wbs_ack_o,
  output logic [NR_PORTS-1:0]      wbs_err_o,
  output logic [DW-1:0]            wbs_dat_o,
  output logic                     wbm_cyc_o,
  output logic                     wbm_stb_o,
  output logic                     wbm_we_o,
  output logic [AW-1:0]            wbm_adr_o,
  output logic [DW-1:0]            wbm_dat_o,
  output logic [DW/8-1:0]          wbm_sel_o,
  output logic [2:0]               wbm_cti_o,
  output logic [1:0]               wbm_bte_o,
  input  logic                     wbm_ack_i,
  input  logic [DW-1:0]            wbm_dat_i,
  output logic [NR_PORTS-1:0]      grant_o
);

  localparam int         c_iw      = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
  localparam logic [7:0] c_tmo_max = 8'(TIMEOUT);

  arb_state_t             r_state;
  arb_state_t             w_next;
  logic [NR_PORTS-1:0]    r_grant;
  logic [c_iw-1:0]        r_last;
  logic [7:0]             r_tmo;

  logic [NR_PORTS-1:0]    w_pick_grant;
  logic [c_iw-1:0]        w_pick_idx;
  logic                   w_pick_valid;

  logic                   w_cyc, w_stb, w_we;
  logic [AW-1:0]          w_adr;
  logic [DW-1:0]          w_dat;
  logic [DW/8-1:0]        w_sel;
  logic [2:0]             w_cti;
  logic [1:0]             w_bte;
  logic                   w_busy, w_ack, w_end_cti, w_tmo_hit;

  wb_arb_rr_pick #(
    .NR_PORTS (NR_PORTS),
    .IW       (c_iw)
  ) u_pick (
    .i_req   (wbs_cyc_i),
    .i_last  (r_last),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  // Grant is one-hot in BUSY and zero otherwise, so the mux also blanks the master side.
  always_comb begin
    w_cyc = 1'b0;
    w_stb = 1'b0;
    w_we  = 1'b0;
    w_adr = '0;
    w_dat = '0;
    w_sel = '0;
    w_cti = '0;
    w_bte = '0;
    for (int k = 0; k < NR_PORTS; k++) begin
      if (r_grant[k]) begin
        w_cyc = wbs_cyc_i[k];
        w_stb = wbs_stb_i[k];
        w_we  = wbs_we_i[k];
        w_adr = wbs_adr_i[k*AW +: AW];
        w_dat = wbs_dat_i[k*DW +: DW];
        w_sel = wbs_sel_i[k*(DW/8) +: (DW/8)];
        w_cti = wbs_cti_i[k*3 +: 3];
        w_bte = wbs_bte_i[k*2 +: 2];
      end
    end
  end

  assign w_busy    = (r_state == ST_BUSY);
  assign w_ack     = w_busy & wbm_ack_i;
  assign w_end_cti = (w_cti == CTI_CLASSIC) || (w_cti == CTI_EOB);
  assign w_tmo_hit = w_busy && (r_tmo == c_tmo_max);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_pick_valid) w_next = ST_BUSY;
      ST_BUSY:    if ((w_ack && w_end_cti) || !w_cyc || w_tmo_hit) w_next = ST_RELEASE;
      ST_RELEASE: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_grant <= '0;
      r_last  <= c_iw'(NR_PORTS - 1);
      r_tmo   <= '0;
    end else begin
      if (r_state == ST_IDLE && w_pick_valid) begin
        r_grant <= w_pick_grant;
        r_last  <= w_pick_idx;
        r_tmo   <= '0;
      end else if (w_busy) begin
        if (w_next != ST_BUSY) r_grant <= '0;
        if (wbm_ack_i)                        r_tmo <= '0;
        else if (w_stb && r_tmo != c_tmo_max) r_tmo <= r_tmo + 8'd1;
      end
    end
  end

  assign wbm_cyc_o = w_cyc;
  assign wbm_stb_o = w_stb;
  assign wbm_we_o  = w_we;
  assign wbm_adr_o = w_adr;
  assign wbm_dat_o = w_dat;
  assign wbm_sel_o = w_sel;
  assign wbm_cti_o = w_cti;
  assign wbm_bte_o = w_bte;

  assign wbs_ack_o = r_grant & {NR_PORTS{wbm_ack_i}};
  assign wbs_err_o = r_grant & {NR_PORTS{w_tmo_hit}};
  assign wbs_dat_o = w_busy ? wbm_dat_i : '0;
  assign grant_o   = r_grant;

endmodule

`default_nettype wire

// File: tb/tb_wb_sdram_port_arbiter.sv
// ============================================================================
// tb_wb_sdram_port_arbiter : directed self-checking bench for the port arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_wb_sdram_port_arbiter;
  import wb_arb_pkg::*;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic [2:0]  wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [89:0] wbs_adr_i;
  logic [95:0] wbs_dat_i;
  logic [11:0] wbs_sel_i;
  logic [8:0]  wbs_cti_i;
  logic [5:0]  wbs_bte_i;
  logic [2:0]  wbs_ack_o, wbs_err_o;
  logic [31:0] wbs_dat_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [29:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;
  logic [2:0]  grant_o;

  int checks = 0;
  int errors = 0;

  wb_sdram_port_arbiter #(
    .NR_PORTS (3),
    .AW       (30),
    .DW       (32),
    .TIMEOUT  (255)
  ) dut (
    .wb_clk    (wb_clk),
    .wb_rst    (wb_rst),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_cti_i (wbs_cti_i),
    .wbs_bte_i (wbs_bte_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_err_o (wbs_err_o),
    .wbs_dat_o (wbs_dat_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_cti_o (wbm_cti_o),
    .wbm_bte_o (wbm_bte_o),
    .wbm_ack_i (wbm_ack_i),
    .wbm_dat_i (wbm_dat_i),
    .grant_o   (grant_o)
  );

  always #5 wb_clk = ~wb_clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int k, input logic cyc, input logic [29:0] adr,
                          input logic [2:0] cti, input logic [1:0] bte);
    wbs_cyc_i[k]            = cyc;
    wbs_stb_i[k]            = cyc;
    wbs_we_i[k]             = 1'b0;
    wbs_adr_i[k*30 +: 30]   = adr;
    wbs_dat_i[k*32 +: 32]   = {2'b00, adr};
    wbs_sel_i[k*4 +: 4]     = 4'hF;
    wbs_cti_i[k*3 +: 3]     = cti;
    wbs_bte_i[k*2 +: 2]     = bte;
  endtask

  // Acts as the controller: one ack per cycle, the owner's cti ending with end_cti.
  task automatic serve(input int port, input int beats, input logic [2:0] end_cti,
                       input logic [31:0] base);
    logic [2:0] oh;
    logic [2:0] c;
    oh = 3'b001 << port;
    for (int b = 0; b < beats; b++) begin
      c = (b == beats - 1) ? end_cti : CTI_INC;
      wbs_cti_i[port*3 +: 3] = c;
      wbm_ack_i = 1'b1;
      wbm_dat_i = base + 32'(b);
      #1;
      chk("beat_grant", 64'(grant_o), 64'(oh));
      chk("beat_ack", 64'(wbs_ack_o), 64'(oh));
      chk("beat_dat", 64'(wbs_dat_o), 64'(base + 32'(b)));
      chk("beat_cti", 64'(wbm_cti_o), 64'(c));
      @(negedge wb_clk);
    end
    wbm_ack_i = 1'b0;
  endtask

  // Called in the RELEASE cycle: owner drops, then one idle cycle follows.
  task automatic release_gap(input int drop);
    set_port(drop, 1'b0, 30'h0, CTI_CLASSIC, BTE_LINEAR);
    #1;
    chk("rel_grant", 64'(grant_o), 64'd0);
    chk("rel_cyc", 64'(wbm_cyc_o), 64'd0);
    @(negedge wb_clk);
    #1;
    chk("idle_grant", 64'(grant_o), 64'd0);
    @(negedge wb_clk);
  endtask

  initial begin
    wb_rst    = 1'b1;
    wbs_cyc_i = '0; wbs_stb_i = '0; wbs_we_i = '0;
    wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '0;
    wbs_cti_i = '0; wbs_bte_i = '0;
    wbm_ack_i = 1'b0; wbm_dat_i = '0;

    // Reset state
    @(negedge wb_clk); #1;
    chk("rst_grant", 64'(grant_o), 64'd0);
    chk("rst_cyc", 64'(wbm_cyc_o), 64'd0);
    chk("rst_stb", 64'(wbm_stb_o), 64'd0);
    chk("rst_ack", 64'(wbs_ack_o), 64'd0);
    chk("rst_err", 64'(wbs_err_o), 64'd0);
    @(negedge wb_clk);
    wb_rst = 1'b0;

    // Three simultaneous 4-beat bursts serviced 0,1,2 without interleaving
    set_port(0, 1'b1, 30'h10, CTI_INC, 2'b00);
    set_port(1, 1'b1, 30'h20, CTI_INC, 2'b00);
    set_port(2, 1'b1, 30'h30, CTI_INC, 2'b10);
    #1;
    chk("t2_idle", 64'(grant_o), 64'd0);
    @(negedge wb_clk); #1;
    chk("t2_first", 64'(grant_o), 64'b001);
    chk("t2_adr0", 64'(wbm_adr_o), 64'h10);
    serve(0, 4, CTI_EOB, 32'hA000);
    release_gap(0);
    #1;
    chk("t2_second", 64'(grant_o), 64'b010);
    serve(1, 4, CTI_EOB, 32'hB000);
    release_gap(1);
    #1;
    chk("t2_third", 64'(grant_o), 64'b100);
    chk("t2_bte", 64'(wbm_bte_o), 64'b10);
    serve(2, 4, CTI_EOB, 32'hC000);
    release_gap(2);

    // Classic read by port1; a stray ack while idle is not forwarded
    wbm_ack_i = 1'b1;
    set_port(1, 1'b1, 30'h100, CTI_CLASSIC, 2'b00);
    #1;
    chk("t1_stray_ack", 64'(wbs_ack_o), 64'd0);
    wbm_ack_i = 1'b0;
    @(negedge wb_clk); #1;
    chk("t1_grant", 64'(grant_o), 64'b010);
    chk("t1_cyc", 64'(wbm_cyc_o), 64'd1);
    chk("t1_adr", 64'(wbm_adr_o), 64'h100);
    chk("t1_noack", 64'(wbs_ack_o), 64'd0);
    serve(1, 1, CTI_CLASSIC, 32'hDEADBEEF);
    release_gap(1);

    // Port2 bursting while port0 waits
    set_port(2, 1'b1, 30'h200, CTI_INC, 2'b00);
    @(negedge wb_clk); #1;
    chk("t3_grant2", 64'(grant_o), 64'b100);
    set_port(0, 1'b1, 30'h300, CTI_CLASSIC, 2'b00);
    serve(2, 4, CTI_EOB, 32'hC100);
    release_gap(2);
    #1;
    chk("t3_grant0", 64'(grant_o), 64'b001);
    chk("t3_adr0", 64'(wbm_adr_o), 64'h300);
    serve(0, 1, CTI_CLASSIC, 32'h1234);
    release_gap(0);

    // Port0 aborts an 8-beat burst after beat 2
    set_port(0, 1'b1, 30'h400, CTI_INC, 2'b00);
    @(negedge wb_clk); #1;
    chk("t4_grant0", 64'(grant_o), 64'b001);
    set_port(1, 1'b1, 30'h500, CTI_CLASSIC, 2'b00);
    serve(0, 2, CTI_INC, 32'hD000);
    set_port(0, 1'b0, 30'h0, CTI_CLASSIC, 2'b00);
    #1;
    chk("t4_abort_cyc", 64'(wbm_cyc_o), 64'd0);
    chk("t4_abort_grant", 64'(grant_o), 64'b001);
    @(negedge wb_clk); #1;
    chk("t4_rel_grant", 64'(grant_o), 64'd0);
    @(negedge wb_clk); #1;
    chk("t4_idle_grant", 64'(grant_o), 64'd0);
    @(negedge wb_clk); #1;
    chk("t4_grant1", 64'(grant_o), 64'b010);
    chk("t4_adr1", 64'(wbm_adr_o), 64'h500);
    serve(1, 1, CTI_CLASSIC, 32'h5555);
    release_gap(1);

    // No ack from the controller: forced release with err after 255 waiting cycles
    set_port(2, 1'b1, 30'h600, CTI_CLASSIC, 2'b00);
    @(negedge wb_clk);
    for (int k = 0; k < 255; k++) begin
      #1;
      chk("t5_err_early", 64'(wbs_err_o), 64'd0);
      chk("t5_hold", 64'(grant_o), 64'b100);
      @(negedge wb_clk);
    end
    #1;
    chk("t5_err", 64'(wbs_err_o), 64'b100);
    chk("t5_grant_at_tmo", 64'(grant_o), 64'b100);
    @(negedge wb_clk);
    set_port(2, 1'b0, 30'h0, CTI_CLASSIC, 2'b00);
    #1;
    chk("t5_err_off", 64'(wbs_err_o), 64'd0);
    chk("t5_released", 64'(grant_o), 64'd0);
    @(negedge wb_clk);

    // Reset in the middle of port1's burst
    set_port(1, 1'b1, 30'h700, CTI_INC, 2'b00);
    @(negedge wb_clk); #1;
    chk("t6_grant1", 64'(grant_o), 64'b010);
    serve(1, 2, CTI_INC, 32'hE000);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'hCAFE0000;
    wb_rst    = 1'b1;
    #1;
    chk("t6_grant", 64'(grant_o), 64'd0);
    chk("t6_cyc", 64'(wbm_cyc_o), 64'd0);
    chk("t6_stb", 64'(wbm_stb_o), 64'd0);
    chk("t6_adr", 64'(wbm_adr_o), 64'd0);
    chk("t6_ack", 64'(wbs_ack_o), 64'd0);
    chk("t6_dat", 64'(wbs_dat_o), 64'd0);
    wbm_ack_i = 1'b0;
    @(negedge wb_clk);
    wb_rst = 1'b0;
    set_port(0, 1'b1, 30'h800, CTI_CLASSIC, 2'b00);
    set_port(2, 1'b1, 30'h900, CTI_CLASSIC, 2'b00);
    #1;
    chk("t6_idle", 64'(grant_o), 64'd0);
    @(negedge wb_clk); #1;
    chk("t6_port0_first", 64'(grant_o), 64'b001);
    chk("t6_adr0", 64'(wbm_adr_o), 64'h800);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
